dp_alu: RTL

Two-lane 32-bit datapath unit sitting directly downstream of `reg_bank`. It consumes `outA`/`outB` as operands and computes lane-wise arithmetic, logic, shift or iterative multiply on the high ([63:32]) and low ([31:0]) words. It returns the 64-bit result with a one-cycle write strobe intended for `reg_bank` `inA`/`regwen`. A start/busy/done handshake lets the sequencer pace reads and write-back.

---
 rtl/dp_alu_if.sv | 22 ++
 rtl/dp_alu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dp_alu_if.sv
// rtl/dp_alu_if.sv - sequencer-side handshake and operand/result bus for dp_alu
interface dp_alu_if;
  logic        start;
  logic [2:0]  op;
  logic [63:0] opA;
  logic [63:0] opB;
  logic [63:0] result;
  logic [3:0]  flags;
  logic        wen;
  logic        done;
  logic        busy;

  modport master (
    output start, op, opA, opB,
    input  result, flags, wen, done, busy
  );

  modport slave (
    input  start, op, opA, opB,
    output result, flags, wen, done, busy
  );
endinterface

// File: rtl/dp_alu.sv
// rtl/dp_alu.sv - two-lane 32-bit ALU feeding reg_bank write-back, with start/busy/done pacing
// DP_ALU_MUL_EN: builds the shift-add multiplier for op 101; otherwise op 101 completes without writing.
module dp_alu #(
  parameter int MUL_CYCLES = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  dp_alu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // The multiplier walks one operand bit per step, so the iteration count is tied to lane width.
  if (MUL_CYCLES != 32) begin : g_mul_cycles_check
    $error("dp_alu: MUL_CYCLES must equal the lane width (32)");
  end

  state_t      state_q;
  logic [63:0] result_q;
  logic [3:0]  flags_q;
  logic        done_q;
  logic        wen_q;
  logic        busy_q;

  // Bit 32 of the return value is the lane carry (ADD) or borrow (SUB).
  function automatic logic [32:0] lane_op(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL:  r = {1'b0, a << b[4:0]};
      OP_SHR:  r = {1'b0, $signed(a) >>> b[4:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [32:0] hi_w;
  logic [32:0] lo_w;

  assign hi_w = lane_op(bus.op, bus.opA[63:32], bus.opB[63:32]);
  assign lo_w = lane_op(bus.op, bus.opA[31:0],  bus.opB[31:0]);

`ifdef DP_ALU_MUL_EN
  localparam logic [4:0] LAST_ITER = 5'(MUL_CYCLES - 1);

  logic [63:0] mul_a_q;
  logic [63:0] mul_b_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [4:0]  cnt_q;

  always_comb begin
    acc_d = acc_q;
    if (mul_b_q[32]) acc_d[63:32] = acc_q[63:32] + mul_a_q[63:32];
    if (mul_b_q[0])  acc_d[31:0]  = acc_q[31:0]  + mul_a_q[31:0];
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DP_ALU_MUL_EN
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      wen_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
`ifdef DP_ALU_MUL_EN
              mul_a_q <= bus.opA;
              mul_b_q <= bus.opB;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= MUL;
`else
              done_q  <= 1'b1;
`endif
            end else begin
              result_q <= {hi_w[31:0], lo_w[31:0]};
              flags_q  <= {hi_w[32], lo_w[32], hi_w[31:0] == 32'd0, lo_w[31:0] == 32'd0};
              done_q   <= 1'b1;
              wen_q    <= 1'b1;
            end
          end
        end
`ifdef DP_ALU_MUL_EN
        MUL: begin
          acc_q   <= acc_d;
          mul_a_q <= {mul_a_q[62:32], 1'b0, mul_a_q[30:0], 1'b0};
          mul_b_q <= {1'b0, mul_b_q[63:33], 1'b0, mul_b_q[31:1]};
          cnt_q   <= cnt_q + 5'd1;
          // The final step's sum goes straight to the result so done lines up with DONE.
          if (cnt_q == LAST_ITER) begin
            result_q <= acc_d;
            flags_q  <= {2'b00, acc_d[63:32] == 32'd0, acc_d[31:0] == 32'd0};
            done_q   <= 1'b1;
            wen_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
  assign bus.wen    = wen_q;
  assign bus.busy   = busy_q;

endmodule
